// File: rtl/div_arbiter.sv
// Round-robin front end sharing one iterative 32-bit divider between two requesters;
// short-circuits divide-by-zero and zero-dividend, bounds divider waits with a timeout.
module div_arbiter #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_q,
  output logic [31:0] rsp_r,
  output logic [1:0]  rsp_err,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  output logic        div_start,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_e;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               id_q, id_d;
  logic [31:0]        dx_q, dx_d;
  logic [31:0]        dy_q, dy_d;
  logic [31:0]        q_q, q_d;
  logic [31:0]        r_q, r_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               gnt0, gnt1, acc;
  logic [31:0]        acc_x, acc_y;

  // Grant only in IDLE; on contention the pointer picks the winner.
  always_comb begin
    gnt0  = (state_q == IDLE) && req0_valid && (!req1_valid || !ptr_q);
    gnt1  = (state_q == IDLE) && req1_valid && (!req0_valid ||  ptr_q);
    acc   = gnt0 || gnt1;
    acc_x = gnt1 ? req1_x : req0_x;
    acc_y = gnt1 ? req1_y : req0_y;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          id_d  = gnt1;
          ptr_d = ~gnt1;
          if (acc_y == 32'd0) begin
            q_d     = 32'd0;
            r_d     = 32'd0;
            err_d   = ERR_DIV0;
            state_d = RESP;
          end else if (acc_x == 32'd0) begin
            q_d     = 32'd0;
            r_d     = 32'd0;
            err_d   = ERR_OK;
            state_d = RESP;
          end else begin
            dx_d    = acc_x;
            dy_d    = acc_y;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q==0 is the first WAIT cycle, where done may still be the previous op's level.
        if (cnt_q != '0 && div_done) begin
          q_d     = div_q;
          r_d     = div_r;
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          q_d     = 32'd0;
          r_d     = 32'd0;
          err_d   = ERR_TMO;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      dx_q    <= 32'd0;
      dy_q    <= 32'd0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      err_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign div_start  = (state_q == LAUNCH);
  assign div_x      = dx_q;
  assign div_y      = dy_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_q      = q_q;
  assign rsp_r      = r_q;
  assign rsp_err    = err_q;

endmodule
